// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register chain: DEPTH valid/data stages under a valid/ready
// handshake. Bubbles collapse, with synchronous flush and a registered occupancy count.
module pipe_stage_elastic #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 2,
    parameter int CLEAR_DATA = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]            v_reg;
    logic [DEPTH-1:0]            v_next;
    logic [DEPTH-1:0][WIDTH-1:0] d_reg;
    logic [DEPTH-1:0][WIDTH-1:0] d_next;
    logic [DEPTH:0]              mv;
    logic [CW-1:0]               count_reg;
    logic [CW-1:0]               count_next;
    logic                        in_xfer;

    // A stage may advance if it is empty or the stage ahead of it advances;
    // this is purely combinational all the way from out_ready to in_ready.
    always_comb begin
        mv        = '0;
        mv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            mv[i] = !v_reg[i] | mv[i+1];
        end
    end

    assign in_ready = mv[0] & !flush;
    assign in_xfer  = in_valid & in_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;

        if (gi == 0) begin : g_head
            assign src_v = in_xfer;
            assign src_d = in_data;
        end else begin : g_body
            assign src_v = v_reg[gi-1];
            assign src_d = d_reg[gi-1];
        end

        assign v_next[gi] = mv[gi] ? src_v : v_reg[gi];
        // A stage that holds is always valid, so clearing only ever hits emptied stages.
        assign d_next[gi] = (CLEAR_DATA != 0 && !v_next[gi]) ? '0
                          : (mv[gi] ? src_d : d_reg[gi]);
    end

    always_comb begin
        count_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count_next = count_next + CW'(v_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            v_reg     <= '0;
            count_reg <= '0;
        end else begin
            v_reg     <= v_next;
            count_reg <= count_next;
        end
    end

    if (CLEAR_DATA != 0) begin : g_clear
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                d_reg <= '0;
            end else begin
                d_reg <= d_next;
            end
        end
    end else begin : g_noclear
        always_ff @(posedge clk) begin
            d_reg <= d_next;
        end
    end

    assign out_valid = v_reg[DEPTH-1] & !flush;
    assign out_data  = d_reg[DEPTH-1];
    assign count     = count_reg;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomized and directed bench for pipe_stage_elastic, checked against an
// item-list model where each queued item knows which stage it sits in.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DEPTH=3, CLEAR_DATA=1
    logic        a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [63:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [1:0]  a_count;

    // DUT B: DEPTH=1, CLEAR_DATA=0
    logic        b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [63:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [0:0]  b_count;

    pipe_stage_elastic #(.WIDTH(64), .DEPTH(3), .CLEAR_DATA(1)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .count(a_count)
    );

    pipe_stage_elastic #(.WIDTH(64), .DEPTH(1), .CLEAR_DATA(0)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .count(b_count)
    );

    typedef struct {
        logic [63:0] data;
        int          pos;
    } item_t;

    item_t mq[$];
    int    mdepth = 3;
    bit    mclear = 1'b1;
    bit    sel_b  = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_out    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the item list by one clock edge: the front item leaves the last
    // stage if out_ready; every other item moves up if its next stage is free
    // or being vacated; an accepted input lands in stage 0.
    task automatic model_edge(input bit iv, input logic [63:0] id, input bit ordy,
                              input bit fl, input bit rs, input bit irdy);
        bit pop = 1'b0;
        bit moved_prev = 1'b0;
        int old_prev = 0;
        if (rs || fl) begin
            mq.delete();
            return;
        end
        for (int j = 0; j < mq.size(); j++) begin
            bit mvj;
            if (j == 0) mvj = (mq[0].pos != mdepth - 1) || ordy;
            else        mvj = (mq[j].pos + 1 != old_prev) || moved_prev;
            old_prev   = mq[j].pos;
            moved_prev = mvj;
            if (mvj) begin
                if (mq[j].pos == mdepth - 1) pop = 1'b1;
                else mq[j].pos = mq[j].pos + 1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (iv && irdy) mq.push_back('{data: id, pos: 0});
    endtask

    task automatic step(input bit iv, input logic [63:0] id, input bit ordy,
                        input bit fl, input bit rs, output bit accepted);
        bit          exp_irdy, exp_ov, last_v;
        logic [63:0] exp_d;
        bit          g_irdy, g_ov;
        logic [63:0] g_d, g_cnt;
        if (!sel_b) begin
            a_in_valid = iv; a_in_data = id; a_out_ready = ordy; a_flush = fl; a_rst = rs;
        end else begin
            b_in_valid = iv; b_in_data = id; b_out_ready = ordy; b_flush = fl; b_rst = rs;
        end
        #2;
        if (!sel_b) begin
            g_irdy = a_in_ready; g_ov = a_out_valid; g_d = a_out_data; g_cnt = 64'(a_count);
        end else begin
            g_irdy = b_in_ready; g_ov = b_out_valid; g_d = b_out_data; g_cnt = 64'(b_count);
        end
        exp_irdy = !fl && (mq.size() < mdepth || ordy);
        last_v   = mq.size() > 0 && mq[0].pos == mdepth - 1;
        exp_ov   = !fl && last_v;
        exp_d    = last_v ? mq[0].data : 64'h0;
        check("in_ready", 64'(g_irdy), 64'(exp_irdy));
        check("out_valid", 64'(g_ov), 64'(exp_ov));
        check("count", g_cnt, 64'(mq.size()));
        if (mclear || last_v) check("out_data", g_d, exp_d);
        if (g_ov && ordy) begin
            n_out++;
            $display("xfer out dut=%s data=%h count=%0d", sel_b ? "B" : "A", g_d, g_cnt);
        end
        accepted = iv && exp_irdy;
        @(posedge clk);
        model_edge(iv, id, ordy, fl, rs, exp_irdy);
        #1;
    endtask

    initial begin
        bit          acc;
        int          accepted_b;
        int          guard;
        logic [63:0] d;

        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; b_rst = 1'b0;
        mq.delete();

        // reset state and in-order streaming
        step(0, 64'h0, 1, 0, 0, acc);
        for (int i = 1; i <= 3; i++) step(1, 64'(i), 1, 0, 0, acc);
        repeat (4) step(0, 64'h0, 1, 0, 0, acc);

        // backpressure: 0xD refused while full, then accepted alongside 0xA leaving
        step(1, 64'hA, 0, 0, 0, acc);
        step(1, 64'hB, 0, 0, 0, acc);
        step(1, 64'hC, 0, 0, 0, acc);
        step(1, 64'hD, 0, 0, 0, acc);
        check("bp_refused", 64'(acc), 64'h0);
        step(1, 64'hD, 1, 0, 0, acc);
        check("bp_accepted", 64'(acc), 64'h1);
        step(0, 64'h0, 0, 0, 0, acc);
        repeat (5) step(0, 64'h0, 1, 0, 0, acc);

        // bubble collapse
        step(1, 64'h5, 0, 0, 0, acc);
        step(0, 64'h0, 0, 0, 0, acc);
        step(1, 64'h6, 0, 0, 0, acc);
        step(0, 64'h0, 0, 0, 0, acc);
        step(0, 64'h0, 0, 0, 0, acc);

        // flush with input offered
        step(1, 64'h77, 1, 1, 0, acc);
        step(0, 64'h0, 1, 0, 0, acc);

        // reset mid-stream with three items in flight
        for (int i = 0; i < 3; i++) step(1, 64'h100 + 64'(i), 0, 0, 0, acc);
        step(0, 64'h0, 0, 0, 1, acc);
        repeat (4) step(0, 64'h0, 1, 0, 0, acc);

        // random traffic on DUT A
        for (int i = 0; i < 400; i++) begin
            d = {$urandom, $urandom};
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, acc);
        end
        step(0, 64'h0, 0, 0, 1, acc);

        // DUT B: DEPTH=1 without data clearing, out_ready toggling every cycle
        sel_b = 1'b1; mdepth = 1; mclear = 1'b0; mq.delete(); n_out = 0;
        accepted_b = 0; guard = 0;
        d = {$urandom, $urandom};
        while (accepted_b < 100 && guard < 1000) begin
            step(1, d, guard[0], 0, 0, acc);
            if (acc) begin
                accepted_b++;
                d = {$urandom, $urandom};
            end
            guard++;
        end
        check("b_accepted", 64'(accepted_b), 64'd100);
        repeat (4) step(0, 64'h0, 1, 0, 0, acc);
        check("b_delivered", 64'(n_out), 64'd100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
